// File: rtl/l2_snoop_responder_pkg.sv
// Shared encodings for the L2 snoop responder: bus op codes, snoop results,
// MESI states, FSM states and the address offset width.
package l2_snoop_responder_pkg;

  localparam int unsigned OFFSET_BITS = 6;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_INVAL = 3'd3,
    OP_RWIM  = 3'd4
  } snp_op_e;

  typedef enum logic [2:0] {
    SNP_HIT   = 3'b000,
    SNP_HITM  = 3'b001,
    SNP_NOHIT = 3'b010
  } snp_res_e;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RESPOND = 3'd2,
    ST_WB      = 3'd3,
    ST_UPDATE  = 3'd4
  } state_e;

endpackage

// File: rtl/l2_snoop_responder_if.sv
// Snoop-side bus bundle: snooped op handshake, storage lookup, snoop result,
// writeback, MESI update and L1 invalidate. slave = responder, master = environment.
interface l2_snoop_responder_if #(
  parameter int unsigned ways      = 8,
  parameter int unsigned indexBits = 14,
  parameter int unsigned tagBits   = 12,
  parameter int unsigned addrBits  = 32
);
  localparam int unsigned WAY_W = (ways > 1) ? $clog2(ways) : 1;

  logic                 snp_valid;
  logic                 snp_ready;
  logic [2:0]           snp_op;
  logic [addrBits-1:0]  snp_addr;

  logic                 lk_req;
  logic [indexBits-1:0] lk_index;
  logic [tagBits-1:0]   lk_tag;
  logic                 lk_hit;
  logic [WAY_W-1:0]     lk_way;
  logic [1:0]           lk_mesi;

  logic [2:0]           snoopBus;
  logic                 snoop_vld;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [addrBits-1:0]  wb_addr;
  logic [WAY_W-1:0]     wb_way;

  logic                 upd_valid;
  logic [indexBits-1:0] upd_index;
  logic [WAY_W-1:0]     upd_way;
  logic [1:0]           upd_mesi;

  logic                 l1_inval;
  logic [addrBits-1:0]  l1_inval_addr;
  logic                 proto_err;

  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_hit, lk_way, lk_mesi, wb_ready,
    output snp_ready, lk_req, lk_index, lk_tag, snoopBus, snoop_vld,
           wb_valid, wb_addr, wb_way, upd_valid, upd_index, upd_way, upd_mesi,
           l1_inval, l1_inval_addr, proto_err
  );

  modport master (
    output snp_valid, snp_op, snp_addr, lk_hit, lk_way, lk_mesi, wb_ready,
    input  snp_ready, lk_req, lk_index, lk_tag, snoopBus, snoop_vld,
           wb_valid, wb_addr, wb_way, upd_valid, upd_index, upd_way, upd_mesi,
           l1_inval, l1_inval_addr, proto_err
  );

endinterface

// File: rtl/l2_snoop_responder_snoop_mesi_table.sv
// Combinational snoop policy: {op, hit, line state} -> snoop result, new MESI
// state and the writeback / L1-invalidate / protocol-error actions.
module snoop_mesi_table
  import l2_snoop_responder_pkg::*;
(
  input  logic [2:0] op,
  input  logic       hit,
  input  mesi_e      mesi,
  output snp_res_e   result,
  output mesi_e      next_mesi,
  output logic       do_wb,
  output logic       do_inval,
  output logic       err
);

  always_comb begin
    result    = SNP_NOHIT;
    next_mesi = mesi;
    do_wb     = 1'b0;
    do_inval  = 1'b0;
    err       = 1'b0;
    if (hit) begin
      case (op)
        OP_READ: begin
          case (mesi)
            MESI_S, MESI_E: begin
              result    = SNP_HIT;
              next_mesi = MESI_S;
            end
            MESI_M: begin
              result    = SNP_HITM;
              next_mesi = MESI_S;
              do_wb     = 1'b1;
            end
            default: ;
          endcase
        end
        OP_INVAL: begin
          case (mesi)
            MESI_S: begin
              next_mesi = MESI_I;
              do_inval  = 1'b1;
            end
            // Another agent invalidating an exclusively-owned line is a coherence violation.
            MESI_E, MESI_M: err = 1'b1;
            default: ;
          endcase
        end
        OP_RWIM: begin
          case (mesi)
            MESI_S, MESI_E: begin
              result    = SNP_HIT;
              next_mesi = MESI_I;
              do_inval  = 1'b1;
            end
            MESI_M: begin
              result    = SNP_HITM;
              next_mesi = MESI_I;
              do_wb     = 1'b1;
              do_inval  = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/l2_snoop_responder.sv
// L2 bus snoop responder: accepts one snooped op at a time, looks the line up,
// drives the snoop result, writes back Modified data and updates MESI / L1.
module l2_snoop_responder
  import l2_snoop_responder_pkg::*;
#(
  parameter int unsigned ways      = 8,
  parameter int unsigned indexBits = 14,
  parameter int unsigned tagBits   = 12,
  parameter int unsigned lineSize  = 512,
  parameter int unsigned addrBits  = 32
)(
  input logic                  clk,
  input logic                  reset,
  l2_snoop_responder_if.slave  bus
);

  localparam int unsigned OFF_W = $clog2(lineSize / 8);
  localparam int unsigned WAY_W = (ways > 1) ? $clog2(ways) : 1;

  state_e              state_q, state_d;
  logic [2:0]          op_q;
  logic [addrBits-1:0] addr_q;
  logic                hit_q;
  logic [WAY_W-1:0]    way_q;
  mesi_e               cur_q, nxt_q;
  logic                wb_q, inval_q, err_q;

  snp_res_e tbl_res;
  mesi_e    tbl_next;
  logic     tbl_wb, tbl_inval, tbl_err;

  logic     snp_ready, lk_req, snoop_vld, wb_valid, upd_valid, l1_inval, proto_err;
  snp_res_e snoop_res;

  snoop_mesi_table u_table (
    .op        (op_q),
    .hit       (bus.lk_hit),
    .mesi      (mesi_e'(bus.lk_mesi)),
    .result    (tbl_res),
    .next_mesi (tbl_next),
    .do_wb     (tbl_wb),
    .do_inval  (tbl_inval),
    .err       (tbl_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      cur_q   <= MESI_I;
      nxt_q   <= MESI_I;
      wb_q    <= 1'b0;
      inval_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.snp_valid && snp_ready) begin
        op_q   <= bus.snp_op;
        addr_q <= bus.snp_addr;
      end
      if (state_q == ST_RESPOND) begin
        hit_q   <= bus.lk_hit;
        way_q   <= bus.lk_way;
        cur_q   <= mesi_e'(bus.lk_mesi);
        nxt_q   <= tbl_next;
        wb_q    <= tbl_wb;
        inval_q <= tbl_inval;
        err_q   <= tbl_err;
      end
    end
  end

  // Ready is gated by reset so no op can be accepted while reset is held.
  assign snp_ready = (state_q == ST_IDLE) && !reset;

  always_comb begin
    state_d   = state_q;
    lk_req    = 1'b0;
    snoop_vld = 1'b0;
    snoop_res = SNP_NOHIT;
    wb_valid  = 1'b0;
    upd_valid = 1'b0;
    l1_inval  = 1'b0;
    proto_err = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.snp_valid && snp_ready) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        lk_req  = 1'b1;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        snoop_vld = 1'b1;
        snoop_res = tbl_res;
        state_d   = tbl_wb ? ST_WB : ST_UPDATE;
      end
      ST_WB: begin
        wb_valid = 1'b1;
        if (bus.wb_ready) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        upd_valid = hit_q && (nxt_q != cur_q);
        l1_inval  = inval_q;
        proto_err = err_q;
        state_d   = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign bus.snp_ready     = snp_ready;
  assign bus.lk_req        = lk_req;
  assign bus.lk_index      = addr_q[OFF_W +: indexBits];
  assign bus.lk_tag        = addr_q[addrBits-1 -: tagBits];
  assign bus.snoopBus      = snoop_res;
  assign bus.snoop_vld     = snoop_vld;
  assign bus.wb_valid      = wb_valid;
  assign bus.wb_addr       = {addr_q[addrBits-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.wb_way        = way_q;
  assign bus.upd_valid     = upd_valid;
  assign bus.upd_index     = addr_q[OFF_W +: indexBits];
  assign bus.upd_way       = way_q;
  assign bus.upd_mesi      = nxt_q;
  assign bus.l1_inval      = l1_inval;
  assign bus.l1_inval_addr = addr_q;
  assign bus.proto_err     = proto_err;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Directed bench for l2_snoop_responder: hand-computed snoop results, MESI
// updates, writeback timing, L1 invalidates, protocol errors and mid-op reset.
module tb_l2_snoop_responder;

  localparam logic [2:0] R_HIT = 3'b000, R_HITM = 3'b001, R_NOHIT = 3'b010;
  localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;
  localparam logic [2:0] O_RD = 3'd1, O_WR = 3'd2, O_INV = 3'd3, O_RWIM = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  l2_snoop_responder_if #(.ways(8), .indexBits(14), .tagBits(12), .addrBits(32)) bus ();

  l2_snoop_responder #(
    .ways(8), .indexBits(14), .tagBits(12), .lineSize(512), .addrBits(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] addr,
                        input logic hit, input logic [1:0] mesi, input logic [2:0] way,
                        input int delay, input logic [13:0] e_idx, input logic [11:0] e_tag,
                        input logic [31:0] e_wba, input logic [2:0] e_res,
                        input logic e_upd, input logic [1:0] e_mesi,
                        input logic e_inv, input logic e_err, input int e_wb);
    int n;
    @(negedge clk);
    check({nm, ".ready_idle"}, 32'(bus.snp_ready), 32'd1);
    bus.snp_valid = 1'b1;
    bus.snp_op    = op;
    bus.snp_addr  = addr;
    bus.lk_hit    = hit;
    bus.lk_mesi   = mesi;
    bus.lk_way    = way;
    bus.wb_ready  = (delay == 0);
    @(negedge clk);
    bus.snp_valid = 1'b0;
    check({nm, ".lk_req"},   32'(bus.lk_req),    32'd1);
    check({nm, ".lk_index"}, 32'(bus.lk_index),  32'(e_idx));
    check({nm, ".lk_tag"},   32'(bus.lk_tag),    32'(e_tag));
    check({nm, ".busy_rdy"}, 32'(bus.snp_ready), 32'd0);
    @(negedge clk);
    check({nm, ".snoop_vld"}, 32'(bus.snoop_vld), 32'd1);
    check({nm, ".snoopBus"},  32'(bus.snoopBus),  32'(e_res));
    check({nm, ".lk_req_1"},  32'(bus.lk_req),    32'd0);
    @(negedge clk);
    n = 0;
    while (bus.wb_valid && n < 20) begin
      n++;
      check({nm, ".wb_addr"}, bus.wb_addr,       e_wba);
      check({nm, ".wb_way"},  32'(bus.wb_way),   32'(way));
      bus.wb_ready = (n > delay);
      @(negedge clk);
    end
    bus.wb_ready = 1'b0;
    check({nm, ".wb_cycles"}, 32'(n), 32'(e_wb));
    check({nm, ".upd_valid"}, 32'(bus.upd_valid), 32'(e_upd));
    if (e_upd) begin
      check({nm, ".upd_mesi"},  32'(bus.upd_mesi),  32'(e_mesi));
      check({nm, ".upd_index"}, 32'(bus.upd_index), 32'(e_idx));
      check({nm, ".upd_way"},   32'(bus.upd_way),   32'(way));
    end
    check({nm, ".l1_inval"}, 32'(bus.l1_inval), 32'(e_inv));
    if (e_inv) check({nm, ".l1_addr"}, bus.l1_inval_addr, addr);
    check({nm, ".proto_err"}, 32'(bus.proto_err), 32'(e_err));
    check({nm, ".upd_rdy"},   32'(bus.snp_ready), 32'd0);
    @(negedge clk);
    check({nm, ".ready_back"}, 32'(bus.snp_ready), 32'd1);
    check({nm, ".quiet"}, 32'({bus.upd_valid, bus.l1_inval, bus.proto_err, bus.snoop_vld, bus.wb_valid}), 32'd0);
  endtask

  initial begin
    int strobes;
    bus.snp_valid = 1'b0;
    bus.snp_op    = '0;
    bus.snp_addr  = '0;
    bus.lk_hit    = 1'b0;
    bus.lk_way    = '0;
    bus.lk_mesi   = '0;
    bus.wb_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready",    32'(bus.snp_ready), 32'd0);
    check("rst.snoopBus", 32'(bus.snoopBus),  32'(R_NOHIT));
    check("rst.strobes",  32'({bus.lk_req, bus.snoop_vld, bus.wb_valid, bus.upd_valid, bus.l1_inval, bus.proto_err}), 32'd0);
    check("rst.wb_addr",  bus.wb_addr, 32'd0);
    check("rst.l1_addr",  bus.l1_inval_addr, 32'd0);
    check("rst.upd",      32'({bus.upd_index, bus.upd_way, bus.upd_mesi}), 32'd0);
    check("rst.lk",       32'({bus.lk_index, bus.lk_tag}), 32'd0);
    reset = 1'b0;
    #1 check("rst.ready_rel", 32'(bus.snp_ready), 32'd1);

    // name op addr hit mesi way dly idx tag wb_addr res upd newmesi inv err wbcycles
    run_op("rd_E",    O_RD,   32'h0000_1040, 1'b1, M_E, 3'd3, 0, 14'h041, 12'h000, 32'h0000_1040, R_HIT,   1'b1, M_S, 1'b0, 1'b0, 0);
    run_op("rd_M",    O_RD,   32'h0000_1040, 1'b1, M_M, 3'd5, 3, 14'h041, 12'h000, 32'h0000_1040, R_HITM,  1'b1, M_S, 1'b0, 1'b0, 4);
    run_op("rd_M_rdy",O_RD,   32'hABC1_2357, 1'b1, M_M, 3'd1, 0, 14'h48D, 12'hABC, 32'hABC1_2340, R_HITM,  1'b1, M_S, 1'b0, 1'b0, 1);
    run_op("rd_S",    O_RD,   32'hABC1_2357, 1'b1, M_S, 3'd1, 0, 14'h48D, 12'hABC, 32'hABC1_2340, R_HIT,   1'b0, M_S, 1'b0, 1'b0, 0);
    run_op("rd_I",    O_RD,   32'hABC1_2357, 1'b1, M_I, 3'd1, 0, 14'h48D, 12'hABC, 32'hABC1_2340, R_NOHIT, 1'b0, M_I, 1'b0, 1'b0, 0);
    run_op("rwim_S",  O_RWIM, 32'hABC1_2357, 1'b1, M_S, 3'd2, 0, 14'h48D, 12'hABC, 32'hABC1_2340, R_HIT,   1'b1, M_I, 1'b1, 1'b0, 0);
    run_op("rwim_E",  O_RWIM, 32'h0000_1040, 1'b1, M_E, 3'd6, 0, 14'h041, 12'h000, 32'h0000_1040, R_HIT,   1'b1, M_I, 1'b1, 1'b0, 0);
    run_op("rwim_M",  O_RWIM, 32'hFFF0_00C0, 1'b1, M_M, 3'd7, 1, 14'h003, 12'hFFF, 32'hFFF0_00C0, R_HITM,  1'b1, M_I, 1'b1, 1'b0, 2);
    run_op("inv_M",   O_INV,  32'h0000_1040, 1'b1, M_M, 3'd4, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b1, 0);
    run_op("inv_E",   O_INV,  32'h0000_1040, 1'b1, M_E, 3'd4, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_E, 1'b0, 1'b1, 0);
    run_op("inv_S",   O_INV,  32'h0000_1040, 1'b1, M_S, 3'd4, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b1, M_I, 1'b1, 1'b0, 0);
    run_op("wr_M",    O_WR,   32'h0000_1040, 1'b1, M_M, 3'd4, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b0, 0);
    run_op("miss_rd", O_RD,   32'h0000_1040, 1'b0, M_M, 3'd0, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b0, 0);
    run_op("miss_wr", O_WR,   32'h0000_1040, 1'b0, M_M, 3'd0, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b0, 0);
    run_op("miss_inv",O_INV,  32'h0000_1040, 1'b0, M_M, 3'd0, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b0, 0);
    run_op("miss_rwim",O_RWIM,32'h0000_1040, 1'b0, M_S, 3'd0, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_S, 1'b0, 1'b0, 0);
    run_op("op7",     3'd7,   32'h0000_1040, 1'b1, M_M, 3'd2, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_M, 1'b0, 1'b0, 0);
    run_op("op0",     3'd0,   32'h0000_1040, 1'b1, M_S, 3'd2, 0, 14'h041, 12'h000, 32'h0000_1040, R_NOHIT, 1'b0, M_S, 1'b0, 1'b0, 0);

    // Reset asserted while a writeback is pending.
    @(negedge clk);
    bus.snp_valid = 1'b1;
    bus.snp_op    = O_RD;
    bus.snp_addr  = 32'h0000_1040;
    bus.lk_hit    = 1'b1;
    bus.lk_mesi   = M_M;
    bus.lk_way    = 3'd5;
    bus.wb_ready  = 1'b0;
    @(negedge clk);
    bus.snp_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rwb.pre_wb", 32'(bus.wb_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rwb.wb_drop",  32'(bus.wb_valid),  32'd0);
    check("rwb.snoopBus", 32'(bus.snoopBus),  32'(R_NOHIT));
    check("rwb.ready",    32'(bus.snp_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.wb_ready = 1'b1;
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      strobes += int'({1'b0, bus.upd_valid}) + int'({1'b0, bus.l1_inval}) +
                 int'({1'b0, bus.wb_valid}) + int'({1'b0, bus.snoop_vld}) + int'({1'b0, bus.proto_err});
    end
    bus.wb_ready = 1'b0;
    check("rwb.no_strobes", 32'(strobes), 32'd0);
    run_op("post_rst", O_RD, 32'h0000_1040, 1'b1, M_E, 3'd3, 0, 14'h041, 12'h000, 32'h0000_1040, R_HIT, 1'b1, M_S, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
